// File: rtl/image_loader.sv
// Byte-stream to pixel loader: packs BYTES_PER_PIXEL bytes MSB-first into one
// pixel word and writes it to image memory at consecutive pixel addresses.
module image_loader #(
  parameter int MEM_WIDTH       = 100,
  parameter int MEM_HEIGHT      = 100,
  parameter int PIXEL_BIT_COUNT = 32,
  localparam int BYTES_PER_PIXEL = PIXEL_BIT_COUNT / 8,
  localparam int MEM_SIZE        = MEM_WIDTH * MEM_HEIGHT,
  localparam int ADDR_SIZE       = $clog2(MEM_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic                       image_write_en,
  output logic [ADDR_SIZE-1:0]       image_write_addr,
  output logic [PIXEL_BIT_COUNT-1:0] image_write_data,
  output logic                       busy,
  output logic                       done
);

  localparam int BC_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int SEL_W = $clog2(PIXEL_BIT_COUNT);
  localparam logic [ADDR_SIZE-1:0] LAST_PIX  = ADDR_SIZE'(MEM_SIZE - 1);
  localparam logic [BC_W-1:0]      LAST_BYTE = BC_W'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_SIZE-1:0]       pix_q, pix_d;
  logic [BC_W-1:0]            bcnt_q, bcnt_d;
  logic [PIXEL_BIT_COUNT-1:0] acc_q, acc_d, acc_nx;
  logic [ADDR_SIZE-1:0]       addr_q, addr_d;
  logic [PIXEL_BIT_COUNT-1:0] data_q, data_d;
  logic [SEL_W-1:0]           lsb;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    // Byte k of a pixel occupies the k-th byte lane counted from the MSB.
    lsb     = SEL_W'(PIXEL_BIT_COUNT - 8) - SEL_W'({bcnt_q, 3'b000});
    acc_nx  = acc_q;
    acc_nx[lsb +: 8] = byte_data;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = FILL;
          pix_d   = '0;
          bcnt_d  = '0;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (byte_valid) begin
          acc_d = acc_nx;
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = WRITE;
            // Output registers load here so they hold steady until the next pixel.
            addr_d  = pix_q;
            data_d  = acc_nx;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pix_q == LAST_PIX) begin
          state_d = DONE;
        end else begin
          pix_d   = pix_q + 1'b1;
          state_d = FILL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign byte_ready       = (state_q == FILL);
  assign image_write_en   = (state_q == WRITE);
  assign busy             = (state_q == FILL) || (state_q == WRITE);
  assign done             = (state_q == DONE);
  assign image_write_addr = addr_q;
  assign image_write_data = data_q;

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_image_loader;
  localparam int MW  = 4;
  localparam int MH  = 2;
  localparam int PBC = 32;
  localparam int BPP = PBC / 8;
  localparam int MS  = MW * MH;
  localparam int AW  = $clog2(MS);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           byte_valid = 1'b0;
  logic [7:0]     byte_data = 8'h00;
  logic           byte_ready, image_write_en, busy, done;
  logic [AW-1:0]  image_write_addr;
  logic [PBC-1:0] image_write_data;

  image_loader #(.MEM_WIDTH(MW), .MEM_HEIGHT(MH), .PIXEL_BIT_COUNT(PBC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .image_write_en(image_write_en), .image_write_addr(image_write_addr),
    .image_write_data(image_write_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int bidx = 0;
  int st_cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  int base_w, base_d;
  logic [AW-1:0]  wr_addr[$];
  logic [PBC-1:0] wr_data[$];
  int             wr_cyc[$];

  // Model: a load is active, a pixel may be pending its write, bytes collect in a queue.
  bit             m_active, m_wr, m_done;
  int             m_pix;
  logic [7:0]     m_q[$];
  logic [AW-1:0]  m_addr;
  logic [PBC-1:0] m_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  task automatic cyc();
    bit take;
    take = byte_ready && byte_valid;
    @(posedge clk); #1;
    if (take) begin
      bidx++;
      byte_data = 8'(bidx);
    end
  endtask

  task automatic do_start();
    bidx = 0;
    byte_data = 8'h00;
    start = 1'b1;
    st_cyc = cyc_cnt;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 200) begin cyc(); k++; end
    if (!done) tmo(nm);
  endtask

  task automatic model_step();
    if (reset) begin
      m_active = 0; m_wr = 0; m_done = 0; m_pix = 0;
      m_q.delete(); m_addr = '0; m_data = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && !abort) begin m_active = 1; m_pix = 0; m_q.delete(); end
    end else if (m_wr) begin
      m_wr = 0;
      if (abort) m_active = 0;
      else if (m_pix == MS - 1) begin m_active = 0; m_done = 1; end
      else m_pix++;
    end else if (abort) begin
      m_active = 0;
      m_q.delete();
    end else if (byte_valid) begin
      m_q.push_back(byte_data);
      if (m_q.size() == BPP) begin
        m_data = '0;
        foreach (m_q[i]) m_data = (m_data << 8) | PBC'(m_q[i]);
        m_addr = AW'(m_pix);
        m_q.delete();
        m_wr = 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    fork
      forever begin
        @(posedge clk or posedge reset);
        model_step();
      end
      forever begin
        @(negedge clk);
        chk("byte_ready", byte_ready, m_active && !m_wr);
        chk("write_en", image_write_en, m_wr);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("write_addr", image_write_addr, m_addr);
        chk("write_data", image_write_data, m_data);
        if (image_write_en) begin
          wr_addr.push_back(image_write_addr);
          wr_data.push_back(image_write_data);
          wr_cyc.push_back(cyc_cnt);
        end
        if (done) begin done_n++; done_cyc = cyc_cnt; end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", byte_ready, 0);
    chk("rst_wen", image_write_en, 0);
    chk("rst_addr", image_write_addr, 0);
    chk("rst_data", image_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    cyc(); cyc();

    // Full load, no stalls
    base_w = wr_addr.size(); base_d = done_n;
    byte_valid = 1'b1;
    do_start();
    chk("ready_after_start", byte_ready, 1);
    wait_done("full_load");
    cyc(); cyc();
    chk("full_nwrites", wr_addr.size() - base_w, 8);
    chk("full_ndone", done_n - base_d, 1);
    chk("full_busy_after", busy, 0);
    if (wr_addr.size() - base_w == 8) begin
      for (int p = 0; p < 8; p++) begin
        chk("full_addr", wr_addr[base_w+p], p);
        chk("full_data", wr_data[base_w+p], {8'(4*p), 8'(4*p+1), 8'(4*p+2), 8'(4*p+3)});
      end
      chk("full_first", wr_data[base_w], 32'h00010203);
      chk("full_last", wr_data[base_w+7], 32'h1C1D1E1F);
      chk("full_latency", wr_cyc[base_w] - st_cyc, 5);
      chk("full_rate", wr_cyc[base_w+7] - wr_cyc[base_w], 35);
      chk("full_done_lat", done_cyc - wr_cyc[base_w+7], 1);
    end

    // Stall of three cycles between bytes 1 and 2 of pixel 0, then abort during WRITE
    do_start();
    for (int k = 0; k < 20 && bidx < 2; k++) cyc();
    byte_valid = 1'b0;
    repeat (3) cyc();
    byte_valid = 1'b1;
    for (int k = 0; k < 20 && !image_write_en; k++) cyc();
    chk("stall_wen", image_write_en, 1);
    chk("stall_addr", image_write_addr, 0);
    chk("stall_data", image_write_data, 32'h00010203);
    chk("stall_latency", cyc_cnt - st_cyc, 8);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_wr_busy", busy, 0);
    chk("abort_wr_done", done, 0);
    chk("abort_wr_hold_data", image_write_data, 32'h00010203);
    cyc(); cyc();

    // Abort after two bytes of pixel 3, then restart from address 0
    base_w = wr_addr.size(); base_d = done_n;
    do_start();
    for (int k = 0; k < 100 && bidx < 14; k++) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", byte_ready, 0);
    cyc(); cyc(); cyc();
    chk("abort_nwrites", wr_addr.size() - base_w, 3);
    chk("abort_last_addr", image_write_addr, 2);
    chk("abort_ndone", done_n - base_d, 0);
    base_w = wr_addr.size(); base_d = done_n;
    do_start();
    wait_done("restart_load");
    cyc(); cyc();
    chk("restart_nwrites", wr_addr.size() - base_w, 8);
    chk("restart_ndone", done_n - base_d, 1);
    if (wr_addr.size() > base_w) begin
      chk("restart_addr0", wr_addr[base_w], 0);
      chk("restart_data0", wr_data[base_w], 32'h00010203);
    end

    // Asynchronous reset during the write of pixel 5
    base_w = wr_addr.size(); base_d = done_n;
    do_start();
    for (int k = 0; k < 100 && !(image_write_en && image_write_addr == 3'd5); k++) cyc();
    chk("pre_rst_wen", image_write_en, 1);
    reset = 1'b1;
    #1;
    chk("arst_ready", byte_ready, 0);
    chk("arst_wen", image_write_en, 0);
    chk("arst_addr", image_write_addr, 0);
    chk("arst_data", image_write_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    chk("arst_nwrites", wr_addr.size() - base_w, 5);
    chk("arst_ndone", done_n - base_d, 0);

    // start held high through the load and the DONE cycle
    base_w = wr_addr.size(); base_d = done_n;
    bidx = 0; byte_data = 8'h00;
    start = 1'b1;
    cyc();
    wait_done("held_start_load");
    cyc();
    chk("held_idle_busy", busy, 0);
    chk("held_idle_ready", byte_ready, 0);
    start = 1'b0;
    cyc(); cyc();
    chk("held_nwrites", wr_addr.size() - base_w, 8);
    chk("held_ndone", done_n - base_d, 1);
    chk("held_busy", busy, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    cyc(); cyc();
    chk("sa_ready", byte_ready, 0);
    chk("sa_busy", busy, 0);
    start = 1'b0; abort = 1'b0;
    cyc();
    chk("sa_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 100: image width in pixels.
REQ-002 SHALL have parameter MEM_HEIGHT, default 100: image height in pixels.
REQ-003 SHALL have parameter PIXEL_BIT_COUNT, default 32: pixel width in bits, a multiple of 8; BYTES_PER_PIXEL = PIXEL_BIT_COUNT/8; MEM_SIZE = MEM_WIDTH*MEM_HEIGHT; ADDR_SIZE = $clog2(MEM_SIZE).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  load request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  cancel an in-progress load.
REQ-008 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-009 SHALL have port byte_data  input  8  source byte stream.
REQ-010 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have port image_write_en  output  1  write strobe to image memory.
REQ-012 SHALL have port image_write_addr  output  ADDR_SIZE  pixel write address.
REQ-013 SHALL have port image_write_data  output  PIXEL_BIT_COUNT  assembled pixel.
REQ-014 SHALL have port busy  output  1  load in progress; image memory read port unusable.
REQ-015 SHALL have port done  output  1  one-cycle pulse on load completion.

Function
REQ-016 SHALL implement states IDLE, FILL, WRITE, DONE; all outputs SHALL be decoded from registered state/counters, not from inputs.
REQ-017 IDLE: start=1 and abort=0 SHALL clear pixel counter and byte counter to 0 and enter FILL next cycle; otherwise remain IDLE.
REQ-018 FILL: byte_ready SHALL be 1; a byte transfers only when byte_valid=1 and byte_ready=1; byte_valid=0 SHALL leave accumulator and counters unchanged.
REQ-019 Byte order SHALL be MSB-first: byte k of a pixel (k=0..BYTES_PER_PIXEL-1) lands in bits [PIXEL_BIT_COUNT-1-8k -: 8] of image_write_data.
REQ-020 On the transfer of byte BYTES_PER_PIXEL-1, byte counter SHALL return to 0 and state SHALL go to WRITE next cycle.
REQ-021 WRITE: image_write_en SHALL be 1 for exactly that one cycle, byte_ready 0, image_write_addr = pixel counter, image_write_data = assembled pixel.
REQ-022 After WRITE: if pixel counter = MEM_SIZE-1 go to DONE, else increment pixel counter and return to FILL; pixel counter SHALL never exceed MEM_SIZE-1 (no wrap).
REQ-023 DONE: done SHALL be 1 for one cycle, busy 0, then IDLE.
REQ-024 busy SHALL be 1 exactly in FILL and WRITE; image_write_en SHALL be 0 in all states other than WRITE.
REQ-025 abort=1 in FILL or WRITE SHALL go to IDLE next cycle without done; a write already in WRITE that cycle SHALL still complete; partial pixel bytes SHALL be discarded.
REQ-026 start while busy or in DONE SHALL be ignored; abort in IDLE or DONE SHALL have no effect.
REQ-027 Latency: start sampled at cycle N gives byte_ready=1 at N+1; with no stalls, pixel p write strobe at N+1+(p+1)*(BYTES_PER_PIXEL+1)-1; sustained throughput one pixel per BYTES_PER_PIXEL+1 cycles.
REQ-028 image_write_addr and image_write_data SHALL hold their values outside WRITE.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, byte_ready=0, image_write_en=0, image_write_addr=0, image_write_data=0, busy=0, done=0, counters 0, regardless of state.
REQ-030 Reset asserted mid-load SHALL suppress any pending write and done; a new start after release SHALL begin at address 0.

Verification (MEM_WIDTH=4, MEM_HEIGHT=2, PIXEL_BIT_COUNT=32)
REQ-031 Full load, byte_valid always 1, bytes 0x00..0x1F -> 8 writes, addr 0..7, first data 0x00010203, last 0x1C1D1E1F, done pulse one cycle after last write, busy low thereafter.
REQ-032 Stall: byte_valid=0 for 3 cycles between bytes 1 and 2 of pixel 0 -> single write 0x00010203 at addr 0, strobe delayed by 3 cycles.
REQ-033 abort after 2 bytes of pixel 3 -> IDLE next cycle, no done, last write at addr 2; restart loads from addr 0.
REQ-034 Async reset during WRITE of pixel 5 -> all outputs 0 same cycle, no done.
REQ-035 start held high during load and in DONE -> no restart, exactly 8 writes and one done pulse.
REQ-036 start and abort both 1 in IDLE -> remains IDLE, byte_ready 0.
